// File: rtl/dct8_mc_engine_pkg.sv
// Shared types, sizing helpers and the integer DCT-II coefficient table generator
// for the 8-point multi-channel DCT/IDCT engine.
package dct8_mc_engine_pkg;

    localparam int N = 32'sd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cstate_e;

    function automatic int clog2(input int v);
        int r;
        r = 32'sd0;
        while ((32'sd1 <<< r) < v) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    localparam int K_W = clog2(N);

    // round(2048 * cos(m*pi/16)), m = 0..8; 2048 = 2**12 * sqrt(2/8)
    function automatic int cos16(input int m);
        case (m)
            32'sd0:  cos16 = 32'sd2048;
            32'sd1:  cos16 = 32'sd2009;
            32'sd2:  cos16 = 32'sd1892;
            32'sd3:  cos16 = 32'sd1703;
            32'sd4:  cos16 = 32'sd1448;
            32'sd5:  cos16 = 32'sd1138;
            32'sd6:  cos16 = 32'sd784;
            32'sd7:  cos16 = 32'sd400;
            default: cos16 = 32'sd0;
        endcase
    endfunction

    // C[k][n] for N=8, 12 fractional bits; the angle is folded onto 0..pi/2
    function automatic int dct_coeff(input int k, input int n);
        int m;
        m = ((32'sd2 * n + 32'sd1) * k) % 32'sd32;
        if (m > 32'sd16) begin
            m = 32'sd32 - m;
        end
        if (k == 32'sd0) begin
            dct_coeff = 32'sd1448;
        end else if (m > 32'sd8) begin
            dct_coeff = -cos16(32'sd16 - m);
        end else begin
            dct_coeff = cos16(m);
        end
    endfunction

endpackage

// File: rtl/dct8_mc_engine_if.sv
// Streaming sample-in / coefficient-out bundle of the DCT engine, plus its sticky status flags.
interface dct8_mc_engine_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int CH_W  = 2
);
    logic                    din_valid;
    logic signed [IN_W-1:0]  din;
    logic [CH_W-1:0]         din_ch;
    logic                    din_inv;
    logic                    din_ready;
    logic                    dout_valid;
    logic signed [OUT_W-1:0] dout;
    logic [CH_W-1:0]         dout_ch;
    logic                    dout_inv;
    logic                    dout_last;
    logic                    dout_ready;
    logic                    err_frame;
    logic                    err_sat;

    modport master (
        output din_valid, din, din_ch, din_inv, dout_ready,
        input  din_ready, dout_valid, dout, dout_ch, dout_inv, dout_last, err_frame, err_sat
    );

    modport slave (
        input  din_valid, din, din_ch, din_inv, dout_ready,
        output din_ready, dout_valid, dout, dout_ch, dout_inv, dout_last, err_frame, err_sat
    );
endinterface

// File: rtl/dct8_mc_engine_coeff_rom.sv
// Combinational coefficient ROM: returns row k (forward) or column k (inverse) of C as N words.
module dct8_mc_engine_coeff_rom import dct8_mc_engine_pkg::*; #(
    parameter int COEFF_W = 14
) (
    input  logic [K_W-1:0]            k,
    input  logic                      inv,
    output logic signed [COEFF_W-1:0] coeff [N]
);

    logic signed [COEFF_W-1:0] tbl_s [N][N];

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            localparam int CV = dct_coeff(gi, gj);
            assign tbl_s[gi][gj] = COEFF_W'(CV);
        end
    end

    // inverse mode reads the transposed table
    always_comb begin
        for (int n = 0; n < N; n++) begin
            if (inv) begin
                coeff[n] = tbl_s[n][k];
            end else begin
                coeff[n] = tbl_s[k][n];
            end
        end
    end

endmodule

// File: rtl/dct8_mc_engine.sv
// Ping-pong framed DCT/IDCT engine: fills N-sample blocks, then a dot-product stage and a
// round/saturate stage emit one coefficient per cycle under a single stall enable.
module dct8_mc_engine import dct8_mc_engine_pkg::*; #(
    parameter int IN_W      = 12,
    parameter int COEFF_W   = 14,
    parameter int FRAC_BITS = 12,
    parameter int OUT_W     = 16,
    parameter int CH_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    dct8_mc_engine_if.slave    io
);

    localparam int AW = IN_W + COEFF_W + K_W;
    localparam logic [AW:0] RND_HALF = {{(AW + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

    logic signed [IN_W-1:0]    mem_r [2][N];
    logic [1:0]                full_r;
    logic [1:0]                full_next_s;
    logic                      fill_sel_r;
    logic                      fill_sel_next_s;
    logic [K_W-1:0]            fill_idx_r;
    logic [CH_W-1:0]           tag_ch_r [2];
    logic [1:0]                tag_inv_r;
    logic                      din_ready_r;
    logic                      err_frame_r;
    logic                      err_sat_r;

    cstate_e                   state_r;
    cstate_e                   state_next_s;
    logic                      rd_sel_r;
    logic [K_W-1:0]            k_r;

    logic                      adv_s;
    logic                      accept_s;
    logic                      fill_done_s;
    logic                      issue_s;
    logic                      issue_last_s;

    logic signed [COEFF_W-1:0] coeff_s [N];
    logic signed [AW-1:0]      acc_s;
    logic signed [AW:0]        rnd_s;
    logic signed [AW:0]        sh_s;
    logic [AW-OUT_W+1:0]       hi_s;
    logic                      sat_hit_s;
    logic signed [OUT_W-1:0]   sat_y_s;

    logic                      s1_valid_r;
    logic                      s1_last_r;
    logic [CH_W-1:0]           s1_ch_r;
    logic                      s1_inv_r;
    logic signed [AW-1:0]      s1_acc_r;

    logic                      dout_valid_r;
    logic signed [OUT_W-1:0]   dout_r;
    logic [CH_W-1:0]           dout_ch_r;
    logic                      dout_inv_r;
    logic                      dout_last_r;

    function automatic logic signed [AW-1:0] sext_x(input logic signed [IN_W-1:0] v);
        return {{(AW - IN_W){v[IN_W-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] sext_c(input logic signed [COEFF_W-1:0] v);
        return {{(AW - COEFF_W){v[COEFF_W-1]}}, v};
    endfunction

    // handshake qualifiers shared by fill and compute sides
    always_comb begin
        adv_s       = !dout_valid_r || io.dout_ready;
        accept_s    = io.din_valid && din_ready_r;
        fill_done_s = accept_s && (fill_idx_r == K_W'(N - 1));
    end

    // buffer occupancy after this cycle's fill completion and read-side free
    always_comb begin
        full_next_s     = full_r;
        fill_sel_next_s = fill_sel_r;
        if (issue_last_s) begin
            full_next_s[rd_sel_r] = 1'b0;
        end else begin
            full_next_s[rd_sel_r] = full_r[rd_sel_r];
        end
        if (fill_done_s) begin
            full_next_s[fill_sel_r] = 1'b1;
            fill_sel_next_s         = ~fill_sel_r;
        end else begin
            fill_sel_next_s = fill_sel_r;
        end
    end

    // fill counter, block tags, occupancy and frame-error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r      <= 2'b00;
            fill_sel_r  <= 1'b0;
            fill_idx_r  <= '0;
            din_ready_r <= 1'b0;
            err_frame_r <= 1'b0;
            tag_ch_r[0] <= '0;
            tag_ch_r[1] <= '0;
            tag_inv_r   <= 2'b00;
        end else begin
            full_r      <= full_next_s;
            fill_sel_r  <= fill_sel_next_s;
            din_ready_r <= !full_next_s[fill_sel_next_s];
            if (accept_s) begin
                fill_idx_r <= fill_done_s ? '0 : fill_idx_r + K_W'(1);
                if (fill_idx_r == '0) begin
                    tag_ch_r[fill_sel_r]  <= io.din_ch;
                    tag_inv_r[fill_sel_r] <= io.din_inv;
                end else if ((io.din_ch != tag_ch_r[fill_sel_r]) || (io.din_inv != tag_inv_r[fill_sel_r])) begin
                    err_frame_r <= 1'b1;
                end
            end
        end
    end

    // sample storage; contents are only meaningful while the buffer is marked full
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[fill_sel_r][fill_idx_r] <= io.din;
        end
    end

    // compute FSM: state register with read pointer and coefficient index
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            rd_sel_r <= 1'b0;
            k_r      <= '0;
        end else begin
            state_r <= state_next_s;
            if (issue_last_s) begin
                k_r      <= '0;
                rd_sel_r <= ~rd_sel_r;
            end else if (issue_s) begin
                k_r <= k_r + K_W'(1);
            end
        end
    end

    // compute FSM: next state; RUN continues straight into the other buffer when it is waiting
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_last_s && !full_r[~rd_sel_r]) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // compute FSM: issue strobe for one dot product into stage 1
    always_comb begin
        issue_s = 1'b0;
        case (state_r)
            ST_IDLE: issue_s = adv_s && full_r[rd_sel_r];
            ST_RUN:  issue_s = adv_s;
            default: issue_s = 1'b0;
        endcase
        issue_last_s = issue_s && (k_r == K_W'(N - 1));
    end

    dct8_mc_engine_coeff_rom #(
        .COEFF_W (COEFF_W)
    ) u_rom (
        .k     (k_r),
        .inv   (tag_inv_r[rd_sel_r]),
        .coeff (coeff_s)
    );

    // full-precision N-term dot product of the read buffer with the selected ROM row/column
    always_comb begin
        acc_s = '0;
        for (int n = 0; n < N; n++) begin
            acc_s = acc_s + sext_x(mem_r[rd_sel_r][n]) * sext_c(coeff_s[n]);
        end
    end

    // round half up, drop fraction, clamp when the upper bits are not a pure sign extension
    always_comb begin
        rnd_s     = {s1_acc_r[AW-1], s1_acc_r} + RND_HALF;
        sh_s      = rnd_s >>> FRAC_BITS;
        hi_s      = sh_s[AW:OUT_W-1];
        sat_hit_s = !((&hi_s) || !(|hi_s));
        if (!sat_hit_s) begin
            sat_y_s = sh_s[OUT_W-1:0];
        end else if (sh_s[AW]) begin
            sat_y_s = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            sat_y_s = {1'b0, {(OUT_W - 1){1'b1}}};
        end
    end

    // two-stage output pipeline; everything holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_last_r    <= 1'b0;
            s1_ch_r      <= '0;
            s1_inv_r     <= 1'b0;
            s1_acc_r     <= '0;
            dout_valid_r <= 1'b0;
            dout_r       <= '0;
            dout_ch_r    <= '0;
            dout_inv_r   <= 1'b0;
            dout_last_r  <= 1'b0;
            err_sat_r    <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r   <= issue_s;
            s1_last_r    <= issue_last_s;
            s1_ch_r      <= tag_ch_r[rd_sel_r];
            s1_inv_r     <= tag_inv_r[rd_sel_r];
            s1_acc_r     <= acc_s;
            dout_valid_r <= s1_valid_r;
            dout_last_r  <= s1_valid_r && s1_last_r;
            if (s1_valid_r) begin
                dout_r     <= sat_y_s;
                dout_ch_r  <= s1_ch_r;
                dout_inv_r <= s1_inv_r;
                if (sat_hit_s) begin
                    err_sat_r <= 1'b1;
                end
            end
        end
    end

    assign io.din_ready  = din_ready_r;
    assign io.dout_valid = dout_valid_r;
    assign io.dout       = dout_r;
    assign io.dout_ch    = dout_ch_r;
    assign io.dout_inv   = dout_inv_r;
    assign io.dout_last  = dout_last_r;
    assign io.err_frame  = err_frame_r;
    assign io.err_sat    = err_sat_r;

endmodule

// File: tb/tb_dct8_mc_engine.sv
// Directed bench for dct8_mc_engine: DC/impulse transforms, back-pressure, framing error,
// saturation (12-bit output instance) and reset during traffic, all against hand-computed values.
module tb_dct8_mc_engine;

    localparam int IN_W = 12;
    localparam int CH_W = 2;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   t_acc      = 0;
    int   t_first    = 0;
    int   sv   [8];
    int   ev   [24];
    int   ech  [24];
    int   einv [24];
    int   imp_exp [8] = '{354, 490, 462, 416, 354, 278, 191, 98};

    dct8_mc_engine_if #(.IN_W(IN_W), .OUT_W(16), .CH_W(CH_W)) m_if ();
    dct8_mc_engine_if #(.IN_W(IN_W), .OUT_W(12), .CH_W(CH_W)) s_if ();

    dct8_mc_engine #(.IN_W(IN_W), .COEFF_W(14), .FRAC_BITS(12), .OUT_W(16), .CH_W(CH_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .io  (m_if)
    );

    dct8_mc_engine #(.IN_W(IN_W), .COEFF_W(14), .FRAC_BITS(12), .OUT_W(12), .CH_W(CH_W)) u_sat (
        .clk (clk),
        .rst (rst),
        .io  (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drives nb beats of sv[]; beats at index >= sw carry ch1 instead of ch0
    task automatic send_blk(input int nb, input int ch0, input int ch1, input int sw, input bit inv);
        for (int i = 0; i < nb; i++) begin
            int wait_c = 0;
            m_if.din_valid = 1'b1;
            m_if.din       = IN_W'(sv[i]);
            m_if.din_ch    = CH_W'((i >= sw) ? ch1 : ch0);
            m_if.din_inv   = inv;
            @(negedge clk);
            while (!m_if.din_ready && wait_c < 300) begin
                @(negedge clk);
                wait_c++;
            end
            if (wait_c >= 300) begin
                chk("send_timeout", wait_c, 0);
                m_if.din_valid = 1'b0;
                return;
            end
            t_acc = cyc;
            step();
        end
        m_if.din_valid = 1'b0;
    endtask

    // consumes n outputs of the main DUT against ev/ech/einv; bp selects the 1,0,0 ready pattern
    task automatic collect(input int n, input bit bp);
        int idx = 0;
        int budget = 0;
        int hold_v = 0;
        bit held = 1'b0;
        bit first = 1'b1;
        m_if.dout_ready = 1'b1;
        while (idx < n && budget < 400) begin
            @(negedge clk);
            if (held) begin
                chk("hold_valid", int'(m_if.dout_valid), 1);
                chk("hold_data", int'($signed(m_if.dout)), hold_v);
            end
            held = 1'b0;
            if (m_if.dout_valid) begin
                if (first) begin
                    t_first = cyc;
                    first   = 1'b0;
                end
                if (m_if.dout_ready) begin
                    chk($sformatf("dout[%0d]", idx), int'($signed(m_if.dout)), ev[idx]);
                    chk($sformatf("dout_ch[%0d]", idx), int'(m_if.dout_ch), ech[idx]);
                    chk($sformatf("dout_inv[%0d]", idx), int'(m_if.dout_inv), einv[idx]);
                    chk($sformatf("dout_last[%0d]", idx), int'(m_if.dout_last), ((idx % 8) == 7) ? 1 : 0);
                    idx++;
                end else begin
                    held   = 1'b1;
                    hold_v = int'($signed(m_if.dout));
                end
            end
            step();
            budget++;
            m_if.dout_ready = bp ? ((budget % 3) == 0) : 1'b1;
        end
        chk("collect_count", idx, n);
        m_if.dout_ready = 1'b1;
    endtask

    task automatic check_idle_after();
        step();
        step();
        @(negedge clk);
        chk("no_extra_output", int'(m_if.dout_valid), 0);
        step();
    endtask

    task automatic set_exp(input int base, input int kind, input int ch, input int inv);
        for (int i = 0; i < 8; i++) begin
            case (kind)
                0: ev[base + i] = imp_exp[i];
                1: ev[base + i] = (i == 0) ? 283 : 0;
                2: ev[base + i] = 100;
                3: ev[base + i] = (i == 0) ? -141 : 0;
                default: ev[base + i] = 0;
            endcase
            ech[base + i]  = ch;
            einv[base + i] = inv;
        end
    endtask

    initial begin
        int idx;
        int wait_c;
        rst = 1'b1;
        m_if.din_valid = 1'b0; m_if.din = '0; m_if.din_ch = '0; m_if.din_inv = 1'b0; m_if.dout_ready = 1'b1;
        s_if.din_valid = 1'b0; s_if.din = '0; s_if.din_ch = '0; s_if.din_inv = 1'b0; s_if.dout_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout_valid", int'(m_if.dout_valid), 0);
        chk("rst_din_ready", int'(m_if.din_ready), 0);
        chk("rst_dout", int'($signed(m_if.dout)), 0);
        chk("rst_dout_last", int'(m_if.dout_last), 0);
        chk("rst_err_frame", int'(m_if.err_frame), 0);
        step();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("din_ready_after_rst", int'(m_if.din_ready), 1);
        step();

        // 1: DC forward, ch 1
        for (int i = 0; i < 8; i++) sv[i] = 100;
        send_blk(8, 1, 1, 8, 1'b0);
        set_exp(0, 1, 1, 0);
        collect(8, 1'b0);
        chk("latency", t_first - t_acc, 3);
        check_idle_after();

        // 2: DC inverse, ch 2
        for (int i = 0; i < 8; i++) sv[i] = (i == 0) ? 283 : 0;
        send_blk(8, 2, 2, 8, 1'b1);
        set_exp(0, 2, 2, 1);
        collect(8, 1'b0);
        check_idle_after();

        // 3: three blocks back-to-back under back-pressure
        set_exp(0, 0, 1, 0);
        set_exp(8, 2, 2, 1);
        set_exp(16, 3, 3, 0);
        fork
            begin
                for (int i = 0; i < 8; i++) sv[i] = (i == 0) ? 1000 : 0;
                send_blk(8, 1, 1, 8, 1'b0);
                for (int i = 0; i < 8; i++) sv[i] = (i == 0) ? 283 : 0;
                send_blk(8, 2, 2, 8, 1'b1);
                @(negedge clk);
                chk("din_ready_drop", int'(m_if.din_ready), 0);
                step();
                for (int i = 0; i < 8; i++) sv[i] = -50;
                send_blk(8, 3, 3, 8, 1'b0);
            end
            collect(24, 1'b1);
        join
        check_idle_after();
        chk("err_frame_clean", int'(m_if.err_frame), 0);

        // 4: channel tag changes at n=3
        for (int i = 0; i < 8; i++) sv[i] = -50;
        send_blk(8, 0, 2, 3, 1'b0);
        set_exp(0, 3, 0, 0);
        collect(8, 1'b0);
        chk("err_frame_set", int'(m_if.err_frame), 1);
        check_idle_after();

        // 5: saturation on the 12-bit output instance
        chk("err_sat_clear", int'(s_if.err_sat), 0);
        for (int i = 0; i < 8; i++) begin
            wait_c = 0;
            s_if.din_valid = 1'b1;
            s_if.din       = 12'sd2047;
            s_if.din_ch    = 2'd0;
            s_if.din_inv   = 1'b0;
            @(negedge clk);
            while (!s_if.din_ready && wait_c < 100) begin
                @(negedge clk);
                wait_c++;
            end
            step();
        end
        s_if.din_valid = 1'b0;
        chk("sat_send_wait", wait_c, 0);
        idx = 0;
        wait_c = 0;
        while (idx < 8 && wait_c < 100) begin
            @(negedge clk);
            if (s_if.dout_valid) begin
                chk($sformatf("sat_dout[%0d]", idx), int'($signed(s_if.dout)), (idx == 0) ? 2047 : 0);
                idx++;
            end
            step();
            wait_c++;
        end
        chk("sat_count", idx, 8);
        chk("err_sat_set", int'(s_if.err_sat), 1);
        chk("main_err_sat", int'(m_if.err_sat), 0);

        // 6: reset with a partial block queued and a prior block draining
        for (int i = 0; i < 8; i++) sv[i] = 100;
        send_blk(8, 1, 1, 8, 1'b0);
        for (int i = 0; i < 8; i++) sv[i] = 200;
        send_blk(5, 1, 1, 8, 1'b0);
        @(negedge clk);
        chk("busy_before_rst", int'(m_if.dout_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_dout_valid", int'(m_if.dout_valid), 0);
        chk("rst_mid_din_ready", int'(m_if.din_ready), 0);
        chk("rst_mid_err_frame", int'(m_if.err_frame), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ready_back", int'(m_if.din_ready), 1);
        step();
        for (int i = 0; i < 8; i++) sv[i] = (i == 0) ? 1000 : 0;
        send_blk(8, 3, 3, 8, 1'b0);
        set_exp(0, 0, 3, 0);
        collect(8, 1'b0);
        check_idle_after();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
